easyaxi_slv_rd: RTL and testbench
=================================

Name: easyaxi_slv_rd

Overview:
AXI read slave that terminates the AR/R channels driven by the easyaxi master. It queues incoming AR requests in an in-order FIFO and serves them one burst at a time. For every beat it computes the FIXED/INCR/WRAP beat address and returns an address-derived data pattern, so the master's data buffers can be checked by inspection. It also generates rresp errors for illegal or out-of-range requests.

Parameters:
OST_DEPTH, 4, AR request FIFO depth (power of 2, >=2); queued requests, excluding the one being served.
READ_DLY, 0, wait cycles between loading a burst and its first rvalid (0..15).
MEM_BYTES, 256, size of the decoded address window [0, MEM_BYTES); beats at or above it return DECERR.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
axi_slv_arvalid  input  1  AR valid
axi_slv_arready  output  1  AR ready
axi_slv_arid  input  `AXI_ID_W  AR id
axi_slv_araddr  input  `AXI_ADDR_W  AR start address
axi_slv_arlen  input  `AXI_LEN_W  beats-1
axi_slv_arsize  input  `AXI_SIZE_W  log2 bytes/beat
axi_slv_arburst  input  `AXI_BURST_W  FIXED/INCR/WRAP
axi_slv_rvalid  output  1  R valid
axi_slv_rready  input  1  R ready
axi_slv_rid  output  `AXI_ID_W  id of the active burst
axi_slv_rdata  output  `AXI_DATA_W  beat data
axi_slv_rresp  output  `AXI_RESP_W  beat response
axi_slv_rlast  output  1  last beat

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). All state is reset by rst_n.
- Reset values: arready=1 (FIFO empty), rvalid=0, rlast=0, rid=0, rdata=0, rresp=OKAY. FSM=IDLE, FIFO pointers/count=0.
- AR FIFO:
  - push on arvalid&arready; arready = (count != OST_DEPTH), derived from registered count only.
  - When full, a pop in the same cycle does not raise arready until the next cycle.
  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo OST_DEPTH.
  - Total acceptance capacity = OST_DEPTH queued + 1 active.
- FSM states: IDLE, WAIT, DATA.
  - IDLE: if FIFO non-empty, pop and load addr/len/size/burst/id into active registers and clear beat counter. Go to WAIT if READ_DLY>0, else DATA.
  - WAIT: count READ_DLY cycles, then go to DATA.
  - DATA: rvalid=1.
    - On rvalid&rready: if beat==len, go to IDLE; else advance address and increment the beat counter.
    - rid/rdata/rresp/rlast are held stable while rvalid&~rready.
- Latency: with READ_DLY=0, the first rvalid occurs 2 cycles after the AR handshake (FIFO write, then IDLE pop). Consecutive bursts have exactly 1 idle cycle between the last-beat handshake and the next rvalid.
- Responses are returned in acceptance order; rid = arid of the active burst.
- Beat address arithmetic (`AXI_ADDR_W wide, carries beyond that width discarded):
  - incr = 1<<size.
  - FIXED: address constant.
  - INCR: next = (addr & ~(incr-1)) + incr.
  - WRAP: wb = (len+1)<<size; next = (addr & ~(wb-1)) | ((addr+incr) & (wb-1)).
  - WRAP with len not in {1,3,7,15} is treated as INCR.
- rdata = current beat address zero-extended to `AXI_DATA_W. The address is not masked for unaligned starts.
- rresp priority, per beat:
  1. SLVERR, with rdata=0, if arburst==2'b11 (the address is then held FIXED) or (1<<arsize) > `AXI_DATA_W/8.
  2. DECERR, with rdata=0, if beat address >= MEM_BYTES.
  3. Otherwise OKAY.
- rlast=1 only on the beat where beat counter == len. A len=0 burst is a single beat with rlast=1.
- The beat counter is `AXI_LEN_W wide.
- Reset asserted mid-burst: rvalid drops immediately (async), the FIFO is flushed, and the burst is discarded with no completion.

Test Plan:
1. INCR, len=3, size=4B, addr=0x10, rready=1 -> 4 beats, rdata 0x10,0x14,0x18,0x1C, rlast on 4th, rresp OKAY, first rvalid 2 cycles after AR handshake.
2. WRAP, len=3, addr=0x34 -> rdata 0x34,0x38,0x3C,0x30. WRAP, len=7, addr=0x38 -> 0x38,0x3C,0x20,0x24,0x28,0x2C,0x30,0x34.
3. FIXED, len=7, addr=0x30 -> 8 beats all rdata 0x30. Then arburst=2'b11 -> all beats SLVERR with rdata 0, rlast on the final beat.
4. rready=0, issue 6 ARs (ids 0..5) -> 5 accepted (1 active + 4 queued) and arready=0 thereafter. Release rready -> bursts return ids 0..4 in order, one idle cycle between bursts; id 5 is accepted when space frees.
5. INCR, len=3, addr=0xF8, MEM_BYTES=256 -> beats 0xF8,0xFC OKAY, then 0x100,0x104 DECERR with rdata 0. Random rready toggling holds the payload stable.
6. Assert rst_n low during beat 2 of an 8-beat burst -> rvalid=0 immediately, arready=1 after release, a new AR is served normally.

Source files
------------

// File: rtl/easyaxi_slv_rd.sv
// rtl/easyaxi_slv_rd.sv - AXI read slave: in-order AR FIFO, FIXED/INCR/WRAP beat addressing, address-pattern data
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_slv_rd #(
  parameter int OST_DEPTH = 4,
  parameter int READ_DLY  = 0,
  parameter int MEM_BYTES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    axi_slv_arvalid,
  output logic                    axi_slv_arready,
  input  logic [`AXI_ID_W-1:0]    axi_slv_arid,
  input  logic [`AXI_ADDR_W-1:0]  axi_slv_araddr,
  input  logic [`AXI_LEN_W-1:0]   axi_slv_arlen,
  input  logic [`AXI_SIZE_W-1:0]  axi_slv_arsize,
  input  logic [`AXI_BURST_W-1:0] axi_slv_arburst,
  output logic                    axi_slv_rvalid,
  input  logic                    axi_slv_rready,
  output logic [`AXI_ID_W-1:0]    axi_slv_rid,
  output logic [`AXI_DATA_W-1:0]  axi_slv_rdata,
  output logic [`AXI_RESP_W-1:0]  axi_slv_rresp,
  output logic                    axi_slv_rlast
);

  localparam int PTR_W    = $clog2(OST_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int ENT_W    = `AXI_ID_W + `AXI_ADDR_W + `AXI_LEN_W + `AXI_SIZE_W + `AXI_BURST_W;
  localparam int MAX_SIZE = $clog2(`AXI_DATA_W / 8);

  localparam logic [`AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [`AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [`AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

  state_t state, state_nxt;

  logic [ENT_W-1:0] fifo_mem [OST_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  logic [`AXI_ID_W-1:0]    h_id;
  logic [`AXI_ADDR_W-1:0]  h_addr;
  logic [`AXI_LEN_W-1:0]   h_len;
  logic [`AXI_SIZE_W-1:0]  h_size;
  logic [`AXI_BURST_W-1:0] h_burst;

  logic [`AXI_ID_W-1:0]    act_id;
  logic [`AXI_ADDR_W-1:0]  act_addr;
  logic [`AXI_LEN_W-1:0]   act_len;
  logic [`AXI_SIZE_W-1:0]  act_size;
  logic [`AXI_BURST_W-1:0] act_burst;
  logic                    act_slverr;
  logic [`AXI_LEN_W-1:0]   beat;
  logic [3:0]              wait_cnt;

  logic                    beat_done, last_beat, decerr;
  logic [`AXI_ADDR_W-1:0]  incr, wb, addr_nxt;
  logic                    wrap_ok;

  assign axi_slv_arready = (count != CNT_W'(OST_DEPTH));
  assign push            = axi_slv_arvalid && axi_slv_arready;
  assign pop             = (state == S_IDLE) && (count != '0);

  assign {h_id, h_addr, h_len, h_size, h_burst} = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OST_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {axi_slv_arid, axi_slv_araddr, axi_slv_arlen, axi_slv_arsize, axi_slv_arburst};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign beat_done = (state == S_DATA) && axi_slv_rready;
  assign last_beat = (beat == act_len);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pop) state_nxt = (READ_DLY > 0) ? S_WAIT : S_DATA;
      S_WAIT:  if (wait_cnt == 4'(READ_DLY - 1)) state_nxt = S_DATA;
      S_DATA:  if (beat_done && last_beat) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Reserved burst type 2'b11 holds the address, like FIXED; WRAP with an illegal length falls back to INCR.
  always_comb begin
    incr     = `AXI_ADDR_W'(1) << act_size;
    wb       = (`AXI_ADDR_W'(act_len) + 1'b1) << act_size;
    wrap_ok  = (act_len == 8'd1) || (act_len == 8'd3) || (act_len == 8'd7) || (act_len == 8'd15);
    addr_nxt = (act_addr & ~(incr - 1'b1)) + incr;
    case (act_burst)
      2'b00:   addr_nxt = act_addr;
      2'b10:   if (wrap_ok) addr_nxt = (act_addr & ~(wb - 1'b1)) | ((act_addr + incr) & (wb - 1'b1));
      2'b11:   addr_nxt = act_addr;
      default: addr_nxt = (act_addr & ~(incr - 1'b1)) + incr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      act_id     <= '0;
      act_addr   <= '0;
      act_len    <= '0;
      act_size   <= '0;
      act_burst  <= '0;
      act_slverr <= 1'b0;
      beat       <= '0;
      wait_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        act_id     <= h_id;
        act_addr   <= h_addr;
        act_len    <= h_len;
        act_size   <= h_size;
        act_burst  <= h_burst;
        act_slverr <= (h_burst == 2'b11) || (32'(h_size) > 32'(MAX_SIZE));
        beat       <= '0;
        wait_cnt   <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else if (beat_done && !last_beat) begin
        act_addr <= addr_nxt;
        beat     <= beat + 1'b1;
      end
    end
  end

  // Payload is a pure function of the active registers, so it holds while the master stalls.
  assign decerr         = (act_addr >= `AXI_ADDR_W'(MEM_BYTES));
  assign axi_slv_rvalid = (state == S_DATA);
  assign axi_slv_rlast  = (state == S_DATA) && last_beat;
  assign axi_slv_rid    = act_id;
  assign axi_slv_rresp  = act_slverr ? RESP_SLVERR : (decerr ? RESP_DECERR : RESP_OKAY);
  assign axi_slv_rdata  = (act_slverr || decerr) ? '0 : `AXI_DATA_W'(act_addr);

endmodule

// File: tb/tb_easyaxi_slv_rd.sv
// tb/tb_easyaxi_slv_rd.sv - directed self-checking bench for easyaxi_slv_rd
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_slv_rd;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    arvalid = 1'b0;
  logic                    arready;
  logic [`AXI_ID_W-1:0]    arid = '0;
  logic [`AXI_ADDR_W-1:0]  araddr = '0;
  logic [`AXI_LEN_W-1:0]   arlen = '0;
  logic [`AXI_SIZE_W-1:0]  arsize = '0;
  logic [`AXI_BURST_W-1:0] arburst = '0;
  logic                    rvalid;
  logic                    rready = 1'b0;
  logic [`AXI_ID_W-1:0]    rid;
  logic [`AXI_DATA_W-1:0]  rdata;
  logic [`AXI_RESP_W-1:0]  rresp;
  logic                    rlast;

  always #5 clk = ~clk;

  easyaxi_slv_rd #(.OST_DEPTH(4), .READ_DLY(0), .MEM_BYTES(256)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .axi_slv_arvalid (arvalid),
    .axi_slv_arready (arready),
    .axi_slv_arid    (arid),
    .axi_slv_araddr  (araddr),
    .axi_slv_arlen   (arlen),
    .axi_slv_arsize  (arsize),
    .axi_slv_arburst (arburst),
    .axi_slv_rvalid  (rvalid),
    .axi_slv_rready  (rready),
    .axi_slv_rid     (rid),
    .axi_slv_rdata   (rdata),
    .axi_slv_rresp   (rresp),
    .axi_slv_rlast   (rlast)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    int          c;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ar_cnt = 0;
  int          ar_cyc[$];
  beat_t       beats[$];
  bit          stab_en = 1'b0;
  logic        held_pending = 1'b0;
  logic [39:0] held = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Observe at the falling edge: a valid&ready seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (stab_en && held_pending) chk("stable", {rvalid, rid, rdata, rresp, rlast}, held);
    held_pending = rvalid && !rready;
    held         = {rvalid, rid, rdata, rresp, rlast};
    if (rvalid && rready) beats.push_back('{rid, rdata, rresp, rlast, cyc});
    if (arvalid && arready) begin
      ar_cyc.push_back(cyc);
      ar_cnt++;
    end
  end

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(posedge clk); #1;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    @(negedge clk);
    while (!arready && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("ar_accept", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (beats.size() < n && k < 500) begin
      @(posedge clk); #2;
      k++;
    end
    chk("beat_count", beats.size(), n);
  endtask

  task automatic expect_beat(input string tag, input logic [3:0] id, input logic [31:0] data,
                             input logic [1:0] resp, input logic last);
    beat_t b;
    if (beats.size() == 0) begin
      chk(tag, 64'hdead, {id, data, resp, last});
    end else begin
      b = beats.pop_front();
      chk(tag, {b.id, b.data, b.resp, b.last}, {id, data, resp, last});
    end
  endtask

  logic [15:0] rdy_pat = 16'b0110_1001_1100_1010;
  logic [31:0] w7_exp [8];
  int          t4_c [12];

  initial begin
    #1;
    chk("rst_arready", arready, 1'b1);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rid", rid, 4'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rresp", rresp, 2'b00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // INCR len=3 4B from 0x10, latency check
    rready = 1'b1;
    beats.delete(); ar_cyc.delete();
    send_ar(4'd1, 32'h10, 8'd3, 3'd2, 2'b01);
    wait_beats(4);
    if (beats.size() > 0 && ar_cyc.size() > 0) chk("t1_latency", beats[0].c - ar_cyc[0], 2);
    expect_beat("t1_b0", 4'd1, 32'h10, 2'b00, 1'b0);
    expect_beat("t1_b1", 4'd1, 32'h14, 2'b00, 1'b0);
    expect_beat("t1_b2", 4'd1, 32'h18, 2'b00, 1'b0);
    expect_beat("t1_b3", 4'd1, 32'h1C, 2'b00, 1'b1);

    // WRAP len=3 and len=7
    send_ar(4'd2, 32'h34, 8'd3, 3'd2, 2'b10);
    wait_beats(4);
    expect_beat("t2_w4_b0", 4'd2, 32'h34, 2'b00, 1'b0);
    expect_beat("t2_w4_b1", 4'd2, 32'h38, 2'b00, 1'b0);
    expect_beat("t2_w4_b2", 4'd2, 32'h3C, 2'b00, 1'b0);
    expect_beat("t2_w4_b3", 4'd2, 32'h30, 2'b00, 1'b1);
    w7_exp = '{32'h38, 32'h3C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34};
    send_ar(4'd3, 32'h38, 8'd7, 3'd2, 2'b10);
    wait_beats(8);
    for (int i = 0; i < 8; i++) expect_beat($sformatf("t2_w8_b%0d", i), 4'd3, w7_exp[i], 2'b00, i == 7);

    // FIXED, reserved burst, oversize beat
    send_ar(4'd4, 32'h30, 8'd7, 3'd2, 2'b00);
    wait_beats(8);
    for (int i = 0; i < 8; i++) expect_beat($sformatf("t3_fix_b%0d", i), 4'd4, 32'h30, 2'b00, i == 7);
    send_ar(4'd5, 32'h40, 8'd3, 3'd2, 2'b11);
    wait_beats(4);
    for (int i = 0; i < 4; i++) expect_beat($sformatf("t3_rsv_b%0d", i), 4'd5, 32'h0, 2'b10, i == 3);
    send_ar(4'd6, 32'h40, 8'd0, 3'd3, 2'b01);
    wait_beats(1);
    expect_beat("t3_oversize", 4'd6, 32'h0, 2'b10, 1'b1);

    // capacity: 1 active + 4 queued while stalled
    rready = 1'b0;
    beats.delete();
    ar_cnt = 0;
    for (int i = 0; i < 5; i++) send_ar(4'(i), 32'(i * 16), 8'd1, 3'd2, 2'b01);
    @(posedge clk); #1;
    arvalid = 1'b1; arid = 4'd5; araddr = 32'h50; arlen = 8'd1; arsize = 3'd2; arburst = 2'b01;
    repeat (4) @(negedge clk);
    chk("t4_full_arready", arready, 1'b0);
    chk("t4_accepted", ar_cnt, 5);
    @(posedge clk); #1;
    rready = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!arready && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("t4_id5_accept", arready, 1'b1);
      @(posedge clk); #1;
      arvalid = 1'b0;
    end
    wait_beats(12);
    if (beats.size() == 12) begin
      for (int i = 0; i < 12; i++) t4_c[i] = beats[i].c;
      for (int k = 1; k < 6; k++) chk($sformatf("t4_gap%0d", k), t4_c[2 * k] - t4_c[2 * k - 1], 2);
    end
    for (int k = 0; k < 6; k++) begin
      expect_beat($sformatf("t4_id%0d_b0", k), 4'(k), 32'(k * 16), 2'b00, 1'b0);
      expect_beat($sformatf("t4_id%0d_b1", k), 4'(k), 32'(k * 16 + 4), 2'b00, 1'b1);
    end

    // DECERR crossing MEM_BYTES under a stalling master
    beats.delete();
    stab_en = 1'b1;
    fork
      send_ar(4'd7, 32'hF8, 8'd3, 3'd2, 2'b01);
      begin
        for (int i = 0; i < 64 && beats.size() < 4; i++) begin
          @(posedge clk); #1;
          rready = rdy_pat[i % 16];
        end
      end
    join
    wait_beats(4);
    @(posedge clk); #1;
    stab_en = 1'b0;
    rready = 1'b1;
    expect_beat("t5_b0", 4'd7, 32'hF8, 2'b00, 1'b0);
    expect_beat("t5_b1", 4'd7, 32'hFC, 2'b00, 1'b0);
    expect_beat("t5_b2", 4'd7, 32'h0, 2'b11, 1'b0);
    expect_beat("t5_b3", 4'd7, 32'h0, 2'b11, 1'b1);

    // reset mid-burst
    beats.delete();
    send_ar(4'd2, 32'h0, 8'd7, 3'd2, 2'b01);
    wait_beats(1);
    chk("t6_beat2_valid", {rvalid, rdata}, {1'b1, 32'h4});
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rvalid", rvalid, 1'b0);
    chk("t6_rst_rlast", rlast, 1'b0);
    chk("t6_rst_arready", arready, 1'b1);
    beats.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("t6_no_leftover", beats.size(), 0);
    chk("t6_arready", arready, 1'b1);
    send_ar(4'd3, 32'h8, 8'd0, 3'd2, 2'b01);
    wait_beats(1);
    expect_beat("t6_new", 4'd3, 32'h8, 2'b00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
